// File: rtl/pc_redirect_sequencer.sv
// Sequences an EX-stage branch/jump redirect into the fetch front end and flushes the wrong-path instructions.
// Optional REDIRECT_STATS_EN adds saturating counters for accepted and dropped redirect requests.
module pc_redirect_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BranchValid,
  input  logic        PCSrc,
  input  logic [31:0] PCNew,
  input  logic        FrontStall,
  output logic        PCLoad,
  output logic [31:0] PCTarget,
  output logic        FlushIFID,
  output logic        FlushIDEX,
  output logic        Busy,
  output logic        AlignErr,
  output logic [15:0] RedirectCount,
  output logic [15:0] DropCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             align_q, align_d;
  logic             req;
  logic             accept;

  assign req = BranchValid & PCSrc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      target_q <= 32'h0000_0000;
      cnt_q    <= '0;
      align_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      align_q  <= align_d;
    end
  end

  // AlignErr is only ever set on the IDLE->ISSUE edge, so it falls after one cycle.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    align_d   = 1'b0;
    accept    = 1'b0;
    PCLoad    = 1'b0;
    PCTarget  = 32'h0000_0000;
    FlushIFID = 1'b0;
    FlushIDEX = 1'b0;
    Busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept   = 1'b1;
          target_d = {PCNew[31:2], 2'b00};
          align_d  = |PCNew[1:0];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        Busy      = 1'b1;
        PCTarget  = target_q;
        FlushIFID = 1'b1;
        FlushIDEX = 1'b1;
        PCLoad    = ~FrontStall;
        if (!FrontStall) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = FLUSH_INIT;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        Busy      = 1'b1;
        FlushIFID = 1'b1;
        cnt_d     = cnt_q - CNT_ONE;
        // Treat a zero count as the last cycle too so a corrupted count cannot stick here.
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign AlignErr = align_q;

`ifdef REDIRECT_STATS_EN
  logic [15:0] redir_cnt_q, redir_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  // Any request seen outside IDLE belongs to a wrong-path instruction.
  assign drop = req & (state_q != S_IDLE);

  always_comb begin
    redir_cnt_d = redir_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (accept && (redir_cnt_q != 16'hFFFF)) begin
      redir_cnt_d = redir_cnt_q + 16'd1;
    end
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      redir_cnt_q <= 16'h0000;
      drop_cnt_q  <= 16'h0000;
    end else begin
      redir_cnt_q <= redir_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign RedirectCount = redir_cnt_q;
  assign DropCount     = drop_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign RedirectCount = 16'h0000;
  assign DropCount     = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Bench for pc_redirect_sequencer: three instances (FLUSH_CYCLES 0, 1, 3) share one stimulus stream
// and are checked every cycle against a transaction-level reference model.
module tb_pc_redirect_sequencer;

`ifdef REDIRECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int NI = 3;

  logic        Clk;
  logic        Reset;
  logic        BranchValid;
  logic        PCSrc;
  logic [31:0] PCNew;
  logic        FrontStall;

  logic        pcload    [NI];
  logic [31:0] pctarget  [NI];
  logic        flushifid [NI];
  logic        flushidex [NI];
  logic        busy      [NI];
  logic        alignerr  [NI];
  logic [15:0] rcount    [NI];
  logic [15:0] dcount    [NI];

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = idle, 1 = redirect waiting for fetch, 2 = flushing.
  int          fcs  [NI] = '{0, 1, 3};
  int          phase[NI];
  int          left [NI];
  logic [31:0] tgt  [NI];
  bit          al   [NI];
  int          rc   [NI];
  int          dc   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pc_redirect_sequencer #(
      .FLUSH_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
      .CNT_W(3)
    ) u_dut (
      .Clk(Clk),
      .Reset(Reset),
      .BranchValid(BranchValid),
      .PCSrc(PCSrc),
      .PCNew(PCNew),
      .FrontStall(FrontStall),
      .PCLoad(pcload[g]),
      .PCTarget(pctarget[g]),
      .FlushIFID(flushifid[g]),
      .FlushIDEX(flushidex[g]),
      .Busy(busy[g]),
      .AlignErr(alignerr[g]),
      .RedirectCount(rcount[g]),
      .DropCount(dcount[g])
    );
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      phase[i] = 0; left[i] = 0; tgt[i] = 32'h0; al[i] = 1'b0; rc[i] = 0; dc[i] = 0;
    end
  endtask

  task automatic model_step(input bit req, input logic [31:0] pcn, input bit fs);
    for (int i = 0; i < NI; i++) begin
      bit al_next;
      al_next = 1'b0;
      if (phase[i] == 0) begin
        if (req) begin
          tgt[i]   = pcn & 32'hFFFF_FFFC;
          al_next  = (pcn % 4) != 0;
          phase[i] = 1;
          if (rc[i] < 65535) rc[i]++;
        end
      end else begin
        if (req && dc[i] < 65535) dc[i]++;
        if (phase[i] == 1) begin
          if (!fs) begin
            if (fcs[i] == 0) phase[i] = 0;
            else begin phase[i] = 2; left[i] = fcs[i]; end
          end
        end else begin
          left[i]--;
          if (left[i] == 0) phase[i] = 0;
        end
      end
      al[i] = al_next;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      bit e_load, e_ifid, e_idex, e_busy;
      logic [31:0] e_tgt;
      e_busy = (phase[i] != 0);
      e_ifid = (phase[i] != 0);
      e_idex = (phase[i] == 1);
      e_load = (phase[i] == 1) && !FrontStall;
      e_tgt  = (phase[i] == 1) ? tgt[i] : 32'h0;
      chk($sformatf("u%0d.PCLoad", i),    {31'h0, pcload[i]},    {31'h0, e_load});
      chk($sformatf("u%0d.PCTarget", i),  pctarget[i],           e_tgt);
      chk($sformatf("u%0d.FlushIFID", i), {31'h0, flushifid[i]}, {31'h0, e_ifid});
      chk($sformatf("u%0d.FlushIDEX", i), {31'h0, flushidex[i]}, {31'h0, e_idex});
      chk($sformatf("u%0d.Busy", i),      {31'h0, busy[i]},      {31'h0, e_busy});
      chk($sformatf("u%0d.AlignErr", i),  {31'h0, alignerr[i]},  {31'h0, al[i]});
      chk($sformatf("u%0d.RedirectCount", i), {16'h0, rcount[i]}, STATS ? rc[i] : 0);
      chk($sformatf("u%0d.DropCount", i),     {16'h0, dcount[i]}, STATS ? dc[i] : 0);
    end
  endtask

  // Called at the falling edge: apply inputs, then check away from the rising edge.
  task automatic drive(input logic bv, input logic ps, input logic [31:0] pcn, input logic fs);
    BranchValid = bv; PCSrc = ps; PCNew = pcn; FrontStall = fs;
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge Clk);
    if (!Reset) model_reset();
    else model_step(BranchValid & PCSrc, PCNew, FrontStall);
    @(negedge Clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
  endtask

  task automatic basic_redirect(input string pfx);
    drive(1'b1, 1'b1, 32'h0000_0040, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk({pfx, ".c1.PCLoad"},    {31'h0, pcload[1]},    32'h1);
    chk({pfx, ".c1.PCTarget"},  pctarget[1],           32'h0000_0040);
    chk({pfx, ".c1.FlushIFID"}, {31'h0, flushifid[1]}, 32'h1);
    chk({pfx, ".c1.FlushIDEX"}, {31'h0, flushidex[1]}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk({pfx, ".c2.FlushIFID"}, {31'h0, flushifid[1]}, 32'h1);
    chk({pfx, ".c2.FlushIDEX"}, {31'h0, flushidex[1]}, 32'h0);
    chk({pfx, ".c2.PCLoad"},    {31'h0, pcload[1]},    32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk({pfx, ".c3.Busy"}, {31'h0, busy[1]}, 32'h0);
    tick();
    idle_cycles(4);
  endtask

  initial begin
    BranchValid = 1'b0; PCSrc = 1'b0; PCNew = 32'h0; FrontStall = 1'b0;
    Reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge Clk);
    Reset = 1'b1;

    // Half-requests must never start a redirect, whatever PCNew holds.
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, $urandom, 1'b0);
      tick();
      drive(1'b1, 1'b0, $urandom, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("filter.PCLoad", {31'h0, pcload[1]}, 32'h0);
    chk("filter.Flush",  {30'h0, flushifid[1], flushidex[1]}, 32'h0);
    chk("filter.RedirectCount", {16'h0, rcount[1]}, 32'h0);
    tick();

    basic_redirect("basic");

    // Fetch stalled for three ISSUE cycles.
    drive(1'b1, 1'b1, 32'h0000_1000, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("stall.PCLoad",   {31'h0, pcload[1]}, 32'h0);
      chk("stall.PCTarget", pctarget[1],        32'h0000_1000);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall.release.PCLoad", {31'h0, pcload[1]}, 32'h1);
    tick();
    idle_cycles(4);

    // A second request during ISSUE is wrong-path and is dropped.
    drive(1'b1, 1'b1, 32'h0000_2000, 1'b1);
    tick();
    drive(1'b1, 1'b1, 32'hDEAD_0000, 1'b0);
    chk("wrongpath.PCTarget", pctarget[1], 32'h0000_2000);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrongpath.DropCount", {16'h0, dcount[1]}, STATS ? 32'd1 : 32'd0);
    tick();
    idle_cycles(4);

    // Misaligned target is truncated and flagged for one cycle.
    drive(1'b1, 1'b1, 32'h0000_0043, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("align.PCTarget", pctarget[1],          32'h0000_0040);
    chk("align.AlignErr", {31'h0, alignerr[1]}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("align.AlignErr.fall", {31'h0, alignerr[1]}, 32'h0);
    tick();
    idle_cycles(4);

    // Asynchronous reset after the first FLUSH cycle of the 3-cycle instance.
    drive(1'b1, 1'b1, 32'h0000_0080, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("areset.pre.Busy", {31'h0, busy[2]}, 32'h1);
    tick();
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("areset.Busy",      {31'h0, busy[2]},      32'h0);
    chk("areset.FlushIFID", {31'h0, flushifid[2]}, 32'h0);
    chk("areset.PCLoad",    {31'h0, pcload[2]},    32'h0);
    check_all();
    @(negedge Clk);
    drive(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    tick();
    Reset = 1'b1;
    basic_redirect("postreset");

    // Random traffic with occasional asynchronous resets.
    for (int k = 0; k < 800; k++) begin
      logic bv, ps, fs;
      logic [31:0] pcn;
      bv  = ($urandom_range(0, 3) != 0);
      ps  = ($urandom_range(0, 1) != 0);
      fs  = ($urandom_range(0, 2) == 0);
      pcn = $urandom;
      if (k % 197 == 196) begin
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge Clk);
        drive(bv, ps, pcn, fs);
        tick();
        Reset = 1'b1;
      end else begin
        drive(bv, ps, pcn, fs);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
